bridge_req_arbiter: RTL and testbench
=====================================

# bridge_req_arbiter

Source-side request scheduler for the AHB2AHB bridge. It shares the single request FIFO between NUM_REQ local requesters using round-robin arbitration, and packs each granted transfer into the bridge's 66-bit request packet. It records the owner of every outstanding read so that response-FIFO entries are routed back to the correct requester. It also runs the source sleep handshake: it stops granting, drains outstanding reads, then reports sleep status to the sink side.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- packet_width, 66, request packet width: {rd0_wr1, valid, addr, wr_data}
- NUM_REQ, 2, number of requesters (2..4)
- OUTSTANDING, 4, max reads in flight (power of 2)

Ports:
- i_clk_source  in  1  clock; single clock domain
- i_rst_source  in  1  reset; synchronous, active-high
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_rd0_wr1  in  NUM_REQ  per-requester direction (1 = write)
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester 0 in LSBs
- i_req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data
- o_req_ready  out  NUM_REQ  one-hot grant/accept
- o_rsp_valid  out  NUM_REQ  one-hot read-response strobe
- o_rsp_data  out  DATA_WIDTH  read-response data, shared by all requesters
- o_packet  out  packet_width  request FIFO write data
- o_req_fifo_wr_en  out  1  request FIFO push
- i_req_fifo_full  in  1  request FIFO full
- i_rsp_packet  in  DATA_WIDTH+1  response FIFO head {rd_valid, rd_data}; first-word-fall-through
- i_rsp_fifo_empty  in  1  response FIFO empty
- o_rsp_fifo_rd_en  out  1  response FIFO pop
- i_source_sleep_req  in  1  sleep request
- o_source_sleep_ack  out  1  sleep acknowledge
- o_source_sleep_status  out  1  source asleep; goes to the sink side
- o_err_orphan  out  1  sticky error: response received with no outstanding read

## Operation
- FSM states:
  - NORMAL (2'b00): arbitration is active. Moves to DRAIN when i_source_sleep_req=1.
  - DRAIN (2'b01): no new grants; responses are still popped. Moves to SLEEP when the outstanding-read count is 0.
  - SLEEP (2'b11): no grants. Moves to NORMAL when i_source_sleep_req=0.
- Eligibility: requester i is eligible when all of the following hold:
  - state is NORMAL;
  - i_req_valid[i]=1;
  - i_req_fifo_full=0;
  - the request is a write, or the tag FIFO is not full, or a tag pop occurs in the same cycle.
- Round-robin grant:
  - Search starts at the pointer rr_ptr and wraps modulo NUM_REQ; the first eligible requester is granted.
  - After a grant to requester i, rr_ptr becomes (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- On a grant:
  - o_req_ready[i]=1 and o_req_fifo_wr_en=1.
  - o_packet = {rd0_wr1_i, 1'b1, addr_i, wr_data_i}. For a read, wr_data is zeroed.
  - A read grant pushes tag i into the tag FIFO. Writes are posted and produce no tag.
- When not granting, o_packet=0.
- Response path: when i_rsp_fifo_empty=0:
  - o_rsp_fifo_rd_en=1 and the tag FIFO pops.
  - o_rsp_valid[tag]=1 and o_rsp_data = i_rsp_packet[DATA_WIDTH-1:0].
  - If the tag FIFO is empty, the entry is still popped, no o_rsp_valid is raised, and o_err_orphan is set. o_err_orphan clears only on reset.
- Sleep outputs:
  - o_source_sleep_ack = i_source_sleep_req in NORMAL and DRAIN; 0 in SLEEP.
  - o_source_sleep_status = 1 only in SLEEP.

## Timing
- Request handshake: grant, o_req_ready, o_packet and o_req_fifo_wr_en are combinational in the same cycle as valid. The transfer completes on the clock edge where valid & ready are both 1. The requester must hold its fields stable until it sees ready.
- Response path is zero-latency: o_rsp_valid and o_rsp_data are combinational from the FIFO head in the pop cycle.
- FSM, rr_ptr, the tag FIFO and o_err_orphan are registered. A sleep request sampled in cycle t still permits grants in cycle t; no grant occurs from t+1.
- Simultaneous tag push and pop:
  - Allowed, including when the FIFO is full; count is unchanged.
  - If the FIFO is empty, a same-cycle pop does not see the pushed tag. That pop is an orphan (responses cannot precede requests).
- Tag FIFO pointers are log2(OUTSTANDING) bits and wrap naturally. The count is log2(OUTSTANDING)+1 bits.
- Reset (synchronous, any state, including mid-drain):
  - state=NORMAL, rr_ptr=0, tag FIFO empty, o_err_orphan=0.
  - All outputs are 0 while i_rst_source=1.
- If i_source_sleep_req drops during DRAIN, the FSM still completes the drain, enters SLEEP, then leaves SLEEP on the next cycle.

## Structure
- Shared package bridge_pkg holds:
  - packet field positions: RD0_WR1_BIT = packet_width-1, VALID_BIT = packet_width-2, address field [packet_width-3:DATA_WIDTH], data field [DATA_WIDTH-1:0];
  - state encodings (NORMAL, DRAIN, SLEEP);
  - response packet width DATA_WIDTH+1.
- Sub-module bridge_tag_fifo: synchronous FIFO of log2(NUM_REQ)-bit tags, depth OUTSTANDING, with push/pop/full/empty outputs.

## Test plan
- Round-robin under contention: both requesters post writes continuously with fifo_full=0. Grants alternate 0,1,0,1; packets show bit65=1 and bit64=1.
- Read routing: req0 reads 0x100, then req1 reads 0x200; FIFO returns 0xAAAA then 0xBBBB. Result: o_rsp_valid=01 with 0xAAAA, then 10 with 0xBBBB.
- Tag FIFO full: req0 issues 4 reads with no responses. The 5th read is stalled while req1's write is still granted. One response pop in the same cycle lets the stalled read be granted.
- Backpressure: i_req_fifo_full=1 for 3 cycles. No wr_en, no ready, rr_ptr unchanged. Grants resume on release.
- Sleep: 2 reads outstanding, then sleep_req=1. State is DRAIN until both responses are popped, then SLEEP with status=1 and ack=0. After sleep_req=0, one cycle later the state is NORMAL.
- Orphan/reset: a response arrives with no tags. It is popped, no rsp_valid, o_err_orphan=1. i_rst_source=1 in DRAIN gives all outputs 0 and state NORMAL.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB2AHB bridge source side: default widths,
// request-packet field positions and the source sleep FSM encoding.
package bridge_pkg;

  localparam int BRIDGE_ADDR_WIDTH   = 32;
  localparam int BRIDGE_DATA_WIDTH   = 32;
  localparam int BRIDGE_PACKET_WIDTH = 66;
  localparam int BRIDGE_NUM_REQ      = 2;
  localparam int BRIDGE_OUTSTANDING  = 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_SLEEP  = 2'b11
  } src_state_e;

  // Request packet layout: {rd0_wr1, valid, addr, wr_data}
  function automatic int pkt_rd0_wr1_bit(input int packet_width);
    return packet_width - 1;
  endfunction

  function automatic int pkt_valid_bit(input int packet_width);
    return packet_width - 2;
  endfunction

  function automatic int pkt_addr_msb(input int packet_width);
    return packet_width - 3;
  endfunction

  function automatic int pkt_addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int rsp_packet_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/bridge_req_arbiter_if.sv
// Requester, request-FIFO, response-FIFO and sleep signals of the bridge
// source-side scheduler; master is the arbiter view, slave the environment.
interface bridge_req_arbiter_if
  import bridge_pkg::*;
#(
  parameter int NUM_REQ      = BRIDGE_NUM_REQ,
  parameter int ADDR_WIDTH   = BRIDGE_ADDR_WIDTH,
  parameter int DATA_WIDTH   = BRIDGE_DATA_WIDTH,
  parameter int PACKET_WIDTH = BRIDGE_PACKET_WIDTH
);

  logic [NUM_REQ-1:0]                     i_req_valid;
  logic [NUM_REQ-1:0]                     i_req_rd0_wr1;
  logic [NUM_REQ*ADDR_WIDTH-1:0]          i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]          i_req_wr_data;
  logic [NUM_REQ-1:0]                     o_req_ready;
  logic [NUM_REQ-1:0]                     o_rsp_valid;
  logic [DATA_WIDTH-1:0]                  o_rsp_data;
  logic [PACKET_WIDTH-1:0]                o_packet;
  logic                                   o_req_fifo_wr_en;
  logic                                   i_req_fifo_full;
  logic [rsp_packet_width(DATA_WIDTH)-1:0] i_rsp_packet;
  logic                                   i_rsp_fifo_empty;
  logic                                   o_rsp_fifo_rd_en;
  logic                                   i_source_sleep_req;
  logic                                   o_source_sleep_ack;
  logic                                   o_source_sleep_status;
  logic                                   o_err_orphan;

  modport master (
    input  i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
    input  i_req_fifo_full, i_rsp_packet, i_rsp_fifo_empty, i_source_sleep_req,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_packet, o_req_fifo_wr_en,
    output o_rsp_fifo_rd_en, o_source_sleep_ack, o_source_sleep_status, o_err_orphan
  );

  modport slave (
    output i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
    output i_req_fifo_full, i_rsp_packet, i_rsp_fifo_empty, i_source_sleep_req,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_packet, o_req_fifo_wr_en,
    input  o_rsp_fifo_rd_en, o_source_sleep_ack, o_source_sleep_status, o_err_orphan
  );

endinterface

// File: rtl/bridge_tag_fifo.sv
// Owner-tag FIFO for outstanding reads. A pop on an empty FIFO is ignored,
// and a push while full is accepted only together with a real pop.
module bridge_tag_fifo #(
  parameter int TAG_W = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     pop,
  output logic [TAG_W-1:0]         pop_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_en_s;
  logic             pop_en_s;

  assign empty   = (count_q == {(PTR_W+1){1'b0}});
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign pop_tag = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    pop_en_s  = pop & ~empty;
    push_en_s = push & (~full | pop_en_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_en_s) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {TAG_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bridge_req_arbiter.sv
// Source-side request scheduler: round-robin grant into the request FIFO,
// read-response routing by owner tag, and the source sleep handshake.
module bridge_req_arbiter
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = BRIDGE_ADDR_WIDTH,
  parameter int DATA_WIDTH   = BRIDGE_DATA_WIDTH,
  parameter int packet_width = BRIDGE_PACKET_WIDTH,
  parameter int NUM_REQ      = BRIDGE_NUM_REQ,
  parameter int OUTSTANDING  = BRIDGE_OUTSTANDING
) (
  input  logic                 i_clk_source,
  input  logic                 i_rst_source,
  bridge_req_arbiter_if.master bus
);

  localparam int TAG_W       = tag_width(NUM_REQ);
  localparam int CNT_W       = $clog2(OUTSTANDING) + 1;
  localparam int RD0_WR1_POS = pkt_rd0_wr1_bit(packet_width);
  localparam int VALID_POS   = pkt_valid_bit(packet_width);
  localparam int ADDR_MSB    = pkt_addr_msb(packet_width);
  localparam int ADDR_LSB    = pkt_addr_lsb(DATA_WIDTH);

  src_state_e        state_q, state_d;
  logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              err_orphan_q, err_orphan_d;

  logic [NUM_REQ-1:0]      eligible_s;
  logic                    grant_s;
  logic [TAG_W-1:0]        grant_idx_s;
  logic                    grant_wr_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [packet_width-1:0] packet_s;
  logic                    rsp_pop_s;
  logic                    tag_pop_s;
  logic [NUM_REQ-1:0]      rsp_valid_s;
  logic [DATA_WIDTH-1:0]   rsp_data_s;
  logic                    tag_push_s;
  logic [TAG_W-1:0]        tag_head_s;
  logic                    tag_full_s;
  logic                    tag_empty_s;
  logic [CNT_W-1:0]        tag_count_s;
  logic                    unused_rd_valid;

  // The FIFO's rd_valid flag carries no routing information here.
  assign unused_rd_valid = bus.i_rsp_packet[DATA_WIDTH];

  bridge_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk      (i_clk_source),
    .rst      (i_rst_source),
    .push     (tag_push_s),
    .push_tag (grant_idx_s),
    .pop      (tag_pop_s),
    .pop_tag  (tag_head_s),
    .full     (tag_full_s),
    .empty    (tag_empty_s),
    .count    (tag_count_s)
  );

  // Response pop, eligibility and round-robin search from rr_ptr
  always_comb begin
    rsp_pop_s   = ~i_rst_source & ~bus.i_rsp_fifo_empty;
    tag_pop_s   = rsp_pop_s & ~tag_empty_s;
    eligible_s  = {NUM_REQ{1'b0}};
    grant_s     = 1'b0;
    grant_idx_s = {TAG_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = ~i_rst_source & (state_q == ST_NORMAL) & bus.i_req_valid[i] &
                      ~bus.i_req_fifo_full &
                      (bus.i_req_rd0_wr1[i] | ~tag_full_s | tag_pop_s);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_s && eligible_s[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_s     = 1'b1;
        grant_idx_s = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Grant decode, packet assembly and pointer/tag updates
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    packet_s    = {packet_width{1'b0}};
    grant_wr_s  = bus.i_req_rd0_wr1[grant_idx_s];
    tag_push_s  = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (grant_s) begin
      req_ready_s[grant_idx_s]    = 1'b1;
      packet_s[RD0_WR1_POS]       = grant_wr_s;
      packet_s[VALID_POS]         = 1'b1;
      packet_s[ADDR_MSB:ADDR_LSB] = bus.i_req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      packet_s[DATA_WIDTH-1:0]    = grant_wr_s ?
                                    bus.i_req_wr_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH] :
                                    {DATA_WIDTH{1'b0}};
      tag_push_s                  = ~grant_wr_s;
      rr_ptr_d                    = TAG_W'((int'(grant_idx_s) + 1) % NUM_REQ);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Response routing and sticky orphan detection
  always_comb begin
    rsp_valid_s  = {NUM_REQ{1'b0}};
    rsp_data_s   = {DATA_WIDTH{1'b0}};
    err_orphan_d = err_orphan_q | (rsp_pop_s & tag_empty_s);
    if (tag_pop_s) begin
      rsp_valid_s[tag_head_s] = 1'b1;
    end else begin
      rsp_valid_s = {NUM_REQ{1'b0}};
    end
    if (rsp_pop_s) begin
      rsp_data_s = bus.i_rsp_packet[DATA_WIDTH-1:0];
    end else begin
      rsp_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Sleep FSM next state; DRAIN completes even if the request is withdrawn
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (bus.i_source_sleep_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_DRAIN: begin
        if (tag_count_s == {CNT_W{1'b0}}) begin
          state_d = ST_SLEEP;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SLEEP: begin
        if (!bus.i_source_sleep_req) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_SLEEP;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Control registers
  always_ff @(posedge i_clk_source) begin
    if (i_rst_source) begin
      state_q      <= ST_NORMAL;
      rr_ptr_q     <= {TAG_W{1'b0}};
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign bus.o_req_ready           = req_ready_s;
  assign bus.o_req_fifo_wr_en      = grant_s;
  assign bus.o_packet              = packet_s;
  assign bus.o_rsp_fifo_rd_en      = rsp_pop_s;
  assign bus.o_rsp_valid           = rsp_valid_s;
  assign bus.o_rsp_data            = rsp_data_s;
  assign bus.o_source_sleep_ack    = ~i_rst_source & bus.i_source_sleep_req &
                                     (state_q != ST_SLEEP);
  assign bus.o_source_sleep_status = ~i_rst_source & (state_q == ST_SLEEP);
  assign bus.o_err_orphan          = ~i_rst_source & err_orphan_q;

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Directed bench for bridge_req_arbiter: each task drives one scenario and
// compares outputs against hand-computed values at the falling clock edge.
module tb_bridge_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  bridge_req_arbiter_if #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PACKET_WIDTH(66)
  ) bus ();

  bridge_req_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .packet_width(66), .NUM_REQ(2), .OUTSTANDING(4)
  ) dut (
    .i_clk_source (clk),
    .i_rst_source (rst),
    .bus          (bus)
  );

  function automatic logic [65:0] mk_pkt(input logic wr, input logic [31:0] a, input logic [31:0] d);
    return {wr, 1'b1, a, (wr ? d : 32'h0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.i_req_valid[i]           = v;
    bus.i_req_rd0_wr1[i]         = wr;
    bus.i_req_addr[i*32 +: 32]   = a;
    bus.i_req_wr_data[i*32 +: 32] = d;
  endtask

  task automatic rsp(input logic [31:0] d);
    bus.i_rsp_fifo_empty = 1'b0;
    bus.i_rsp_packet     = {1'b1, d};
  endtask

  task automatic no_rsp();
    bus.i_rsp_fifo_empty = 1'b1;
    bus.i_rsp_packet     = 33'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h1, 32'h2);
    set_req(1, 1'b1, 1'b0, 32'h3, 32'h4);
    bus.i_req_fifo_full    = 1'b0;
    bus.i_source_sleep_req = 1'b1;
    rsp(32'h77);
    settle();
    checks++; if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_req_fifo_wr_en, bus.o_rsp_fifo_rd_en, bus.o_source_sleep_ack, bus.o_source_sleep_status, bus.o_err_orphan} !== 9'b0) begin fails++; $display("FAIL reset_ctrl: got %b expected 0", {bus.o_req_ready, bus.o_rsp_valid, bus.o_req_fifo_wr_en, bus.o_rsp_fifo_rd_en, bus.o_source_sleep_ack, bus.o_source_sleep_status, bus.o_err_orphan}); end
    checks++; if (bus.o_packet !== 66'h0) begin fails++; $display("FAIL reset_packet: got %h expected 0", bus.o_packet); end
    checks++; if (bus.o_rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data: got %h expected 0", bus.o_rsp_data); end
    tick();
    rst = 1'b0;
    bus.i_source_sleep_req = 1'b0;
    bus.i_req_valid = 2'b00;
    no_rsp();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [65:0] exp_pkt;
    set_req(0, 1'b1, 1'b1, 32'h0000_1000, 32'h1111_1111);
    set_req(1, 1'b1, 1'b1, 32'h0000_2000, 32'h2222_2222);
    for (int k = 0; k < 4; k++) begin
      settle();
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_pkt = (k % 2 == 0) ? mk_pkt(1'b1, 32'h0000_1000, 32'h1111_1111) : mk_pkt(1'b1, 32'h0000_2000, 32'h2222_2222);
      checks++; if (bus.o_req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus.o_req_ready, exp_rdy); end
      checks++; if (bus.o_req_fifo_wr_en !== 1'b1) begin fails++; $display("FAIL rr_wr_en[%0d]: got %b expected 1", k, bus.o_req_fifo_wr_en); end
      checks++; if (bus.o_packet !== exp_pkt) begin fails++; $display("FAIL rr_packet[%0d]: got %h expected %h", k, bus.o_packet, exp_pkt); end
      tick();
    end
    bus.i_req_valid = 2'b00;
  endtask

  task automatic test_read_routing();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
    settle();
    checks++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL rd0_ready: got %b expected 01", bus.o_req_ready); end
    checks++; if (bus.o_packet !== 66'h1_0000_0100_0000_0000) begin fails++; $display("FAIL rd0_packet: got %h expected %h", bus.o_packet, 66'h1_0000_0100_0000_0000); end
    tick();
    set_req(0, 1'b0, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'hCAFE_0000);
    settle();
    checks++; if (bus.o_req_ready !== 2'b10) begin fails++; $display("FAIL rd1_ready: got %b expected 10", bus.o_req_ready); end
    checks++; if (bus.o_packet !== mk_pkt(1'b0, 32'h200, 32'h0)) begin fails++; $display("FAIL rd1_packet: got %h expected %h", bus.o_packet, mk_pkt(1'b0, 32'h200, 32'h0)); end
    tick();
    set_req(1, 1'b0, 1'b0, 32'h200, 32'h0);
    rsp(32'h0000_AAAA);
    settle();
    checks++; if ({bus.o_rsp_fifo_rd_en, bus.o_rsp_valid, bus.o_req_ready} !== 5'b1_01_00) begin fails++; $display("FAIL rsp0_strobes: got %b expected 10100", {bus.o_rsp_fifo_rd_en, bus.o_rsp_valid, bus.o_req_ready}); end
    checks++; if (bus.o_rsp_data !== 32'h0000_AAAA) begin fails++; $display("FAIL rsp0_data: got %h expected 0000aaaa", bus.o_rsp_data); end
    tick();
    rsp(32'h0000_BBBB);
    settle();
    checks++; if (bus.o_rsp_valid !== 2'b10) begin fails++; $display("FAIL rsp1_valid: got %b expected 10", bus.o_rsp_valid); end
    checks++; if (bus.o_rsp_data !== 32'h0000_BBBB) begin fails++; $display("FAIL rsp1_data: got %h expected 0000bbbb", bus.o_rsp_data); end
    tick();
    no_rsp();
  endtask

  task automatic test_tag_full();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b0, 32'h300 + 32'(k * 4), 32'h0);
      settle();
      checks++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL fill_ready[%0d]: got %b expected 01", k, bus.o_req_ready); end
      tick();
    end
    set_req(1, 1'b1, 1'b1, 32'h400, 32'h4444_4444);
    settle();
    checks++; if (bus.o_req_ready !== 2'b10) begin fails++; $display("FAIL full_wr_a: got %b expected 10", bus.o_req_ready); end
    tick();
    settle();
    checks++; if (bus.o_req_ready !== 2'b10) begin fails++; $display("FAIL full_skip_rd: got %b expected 10", bus.o_req_ready); end
    checks++; if (bus.o_packet !== mk_pkt(1'b1, 32'h400, 32'h4444_4444)) begin fails++; $display("FAIL full_wr_pkt: got %h expected %h", bus.o_packet, mk_pkt(1'b1, 32'h400, 32'h4444_4444)); end
    tick();
    set_req(1, 1'b0, 1'b1, 32'h400, 32'h0);
    settle();
    checks++; if ({bus.o_req_ready, bus.o_req_fifo_wr_en} !== 3'b000) begin fails++; $display("FAIL full_stall: got %b expected 000", {bus.o_req_ready, bus.o_req_fifo_wr_en}); end
    tick();
    rsp(32'h0000_1234);
    settle();
    checks++; if ({bus.o_req_ready, bus.o_rsp_valid} !== 4'b01_01) begin fails++; $display("FAIL full_push_pop: got %b expected 0101", {bus.o_req_ready, bus.o_rsp_valid}); end
    checks++; if (bus.o_packet !== mk_pkt(1'b0, 32'h30C, 32'h0)) begin fails++; $display("FAIL full_rd_pkt: got %h expected %h", bus.o_packet, mk_pkt(1'b0, 32'h30C, 32'h0)); end
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      rsp(32'h5000 + 32'(k));
      settle();
      checks++; if (bus.o_rsp_valid !== 2'b01) begin fails++; $display("FAIL drain_valid[%0d]: got %b expected 01", k, bus.o_rsp_valid); end
      tick();
    end
    no_rsp();
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 1'b1, 32'h500, 32'h55);
    set_req(1, 1'b1, 1'b1, 32'h600, 32'h66);
    bus.i_req_fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({bus.o_req_ready, bus.o_req_fifo_wr_en} !== 3'b000) begin fails++; $display("FAIL bp_hold[%0d]: got %b expected 000", k, {bus.o_req_ready, bus.o_req_fifo_wr_en}); end
      checks++; if (bus.o_packet !== 66'h0) begin fails++; $display("FAIL bp_packet[%0d]: got %h expected 0", k, bus.o_packet); end
      tick();
    end
    bus.i_req_fifo_full = 1'b0;
    settle();
    checks++; if (bus.o_req_ready !== 2'b10) begin fails++; $display("FAIL bp_resume1: got %b expected 10", bus.o_req_ready); end
    tick();
    settle();
    checks++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL bp_resume0: got %b expected 01", bus.o_req_ready); end
    tick();
    bus.i_req_valid = 2'b00;
  endtask

  task automatic test_sleep();
    set_req(1, 1'b1, 1'b0, 32'h700, 32'h0);
    settle();
    checks++; if (bus.o_req_ready !== 2'b10) begin fails++; $display("FAIL sl_rd1: got %b expected 10", bus.o_req_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, 32'h700, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h710, 32'h0);
    settle();
    checks++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL sl_rd0: got %b expected 01", bus.o_req_ready); end
    tick();
    set_req(0, 1'b1, 1'b1, 32'h800, 32'h88);
    set_req(1, 1'b1, 1'b1, 32'h900, 32'h99);
    bus.i_source_sleep_req = 1'b1;
    settle();
    checks++; if ({bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status} !== 4'b10_1_0) begin fails++; $display("FAIL sl_req_cycle: got %b expected 1010", {bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status}); end
    tick();
    settle();
    checks++; if ({bus.o_req_ready, bus.o_req_fifo_wr_en, bus.o_source_sleep_ack, bus.o_source_sleep_status} !== 5'b00_0_1_0) begin fails++; $display("FAIL sl_drain: got %b expected 00010", {bus.o_req_ready, bus.o_req_fifo_wr_en, bus.o_source_sleep_ack, bus.o_source_sleep_status}); end
    tick();
    rsp(32'h0000_C001);
    settle();
    checks++; if ({bus.o_rsp_valid, bus.o_req_ready} !== 4'b10_00) begin fails++; $display("FAIL sl_pop1: got %b expected 1000", {bus.o_rsp_valid, bus.o_req_ready}); end
    tick();
    rsp(32'h0000_C002);
    settle();
    checks++; if (bus.o_rsp_valid !== 2'b01) begin fails++; $display("FAIL sl_pop0: got %b expected 01", bus.o_rsp_valid); end
    tick();
    no_rsp();
    settle();
    checks++; if ({bus.o_req_ready, bus.o_source_sleep_status} !== 3'b00_0) begin fails++; $display("FAIL sl_last_drain: got %b expected 000", {bus.o_req_ready, bus.o_source_sleep_status}); end
    tick();
    settle();
    checks++; if ({bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status} !== 4'b00_0_1) begin fails++; $display("FAIL sl_asleep: got %b expected 0001", {bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status}); end
    tick();
    bus.i_source_sleep_req = 1'b0;
    settle();
    checks++; if ({bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status} !== 4'b00_0_1) begin fails++; $display("FAIL sl_wake_cycle: got %b expected 0001", {bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status}); end
    tick();
    settle();
    checks++; if ({bus.o_req_ready, bus.o_source_sleep_status} !== 3'b01_0) begin fails++; $display("FAIL sl_normal: got %b expected 010", {bus.o_req_ready, bus.o_source_sleep_status}); end
    tick();
    bus.i_req_valid = 2'b00;
  endtask

  task automatic test_orphan_reset();
    rsp(32'h0000_5555);
    settle();
    checks++; if ({bus.o_rsp_fifo_rd_en, bus.o_rsp_valid, bus.o_err_orphan} !== 4'b1_00_0) begin fails++; $display("FAIL orph_pop: got %b expected 1000", {bus.o_rsp_fifo_rd_en, bus.o_rsp_valid, bus.o_err_orphan}); end
    tick();
    no_rsp();
    settle();
    checks++; if (bus.o_err_orphan !== 1'b1) begin fails++; $display("FAIL orph_flag: got %b expected 1", bus.o_err_orphan); end
    tick();
    set_req(0, 1'b1, 1'b0, 32'hA00, 32'h0);
    rsp(32'h0000_6666);
    settle();
    checks++; if ({bus.o_req_ready, bus.o_rsp_fifo_rd_en, bus.o_rsp_valid} !== 5'b01_1_00) begin fails++; $display("FAIL orph_push_pop: got %b expected 01100", {bus.o_req_ready, bus.o_rsp_fifo_rd_en, bus.o_rsp_valid}); end
    tick();
    set_req(0, 1'b0, 1'b0, 32'hA00, 32'h0);
    rsp(32'h0000_7777);
    settle();
    checks++; if ({bus.o_rsp_valid, bus.o_rsp_data} !== {2'b01, 32'h0000_7777}) begin fails++; $display("FAIL orph_late_rsp: got %b/%h expected 01/00007777", bus.o_rsp_valid, bus.o_rsp_data); end
    tick();
    no_rsp();
    set_req(0, 1'b1, 1'b0, 32'hB00, 32'h0);
    settle();
    checks++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL rst_pre_rd: got %b expected 01", bus.o_req_ready); end
    tick();
    set_req(0, 1'b1, 1'b1, 32'hB04, 32'h1);
    bus.i_source_sleep_req = 1'b1;
    settle();
    checks++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL rst_pre_wr: got %b expected 01", bus.o_req_ready); end
    tick();
    settle();
    checks++; if ({bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status, bus.o_err_orphan} !== 5'b00_1_0_1) begin fails++; $display("FAIL rst_in_drain: got %b expected 00101", {bus.o_req_ready, bus.o_source_sleep_ack, bus.o_source_sleep_status, bus.o_err_orphan}); end
    rst = 1'b1;
    rsp(32'h0000_8888);
    #1;
    checks++; if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_req_fifo_wr_en, bus.o_rsp_fifo_rd_en, bus.o_source_sleep_ack, bus.o_source_sleep_status, bus.o_err_orphan} !== 9'b0) begin fails++; $display("FAIL rst_drain_ctrl: got %b expected 0", {bus.o_req_ready, bus.o_rsp_valid, bus.o_req_fifo_wr_en, bus.o_rsp_fifo_rd_en, bus.o_source_sleep_ack, bus.o_source_sleep_status, bus.o_err_orphan}); end
    checks++; if ({bus.o_packet, bus.o_rsp_data} !== 98'h0) begin fails++; $display("FAIL rst_drain_data: got %h/%h expected 0/0", bus.o_packet, bus.o_rsp_data); end
    tick();
    rst = 1'b0;
    bus.i_source_sleep_req = 1'b0;
    no_rsp();
    set_req(0, 1'b1, 1'b1, 32'hC00, 32'hC0C0_C0C0);
    settle();
    checks++; if ({bus.o_req_ready, bus.o_err_orphan, bus.o_source_sleep_status} !== 4'b01_0_0) begin fails++; $display("FAIL post_rst_normal: got %b expected 0100", {bus.o_req_ready, bus.o_err_orphan, bus.o_source_sleep_status}); end
    tick();
    set_req(0, 1'b0, 1'b1, 32'hC00, 32'h0);
    rsp(32'h0000_9999);
    settle();
    checks++; if ({bus.o_rsp_fifo_rd_en, bus.o_rsp_valid} !== 3'b1_00) begin fails++; $display("FAIL post_rst_tags: got %b expected 100", {bus.o_rsp_fifo_rd_en, bus.o_rsp_valid}); end
    tick();
    no_rsp();
    settle();
    checks++; if (bus.o_err_orphan !== 1'b1) begin fails++; $display("FAIL post_rst_orphan: got %b expected 1", bus.o_err_orphan); end
    tick();
  endtask

  initial begin
    bus.i_req_valid        = 2'b00;
    bus.i_req_rd0_wr1      = 2'b00;
    bus.i_req_addr         = 64'h0;
    bus.i_req_wr_data      = 64'h0;
    bus.i_req_fifo_full    = 1'b0;
    bus.i_rsp_fifo_empty   = 1'b1;
    bus.i_rsp_packet       = 33'h0;
    bus.i_source_sleep_req = 1'b0;
    test_reset();
    test_round_robin();
    test_read_routing();
    test_tag_full();
    test_backpressure();
    test_sleep();
    test_orphan_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
